// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding, RST_CAUSE bit positions, index helper.
// Pure declarations; no logic, no latency, no backpressure.
// Channel indices are fixed at 3 bits, which covers the 1..8 channel range.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD        = 3'd0,
    ST_WAIT_STABLE = 3'd1,
    ST_RELEASE     = 3'd2,
    ST_RUN         = 3'd3,
    ST_SW_HOLD     = 3'd4,
    ST_SW_WAIT     = 3'd5
  } seq_state_e;

  localparam int CAUSE_W    = 5;
  localparam int CAUSE_EXT  = 0;
  localparam int CAUSE_PLL  = 1;
  localparam int CAUSE_INIT = 2;
  localparam int CAUSE_FF   = 3;
  localparam int CAUSE_SW   = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_RST_VAL = 5'b00001;

  // Index of the lowest set bit; 0 when nothing is set (callers gate on "any").
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rst_sync_pf.sv
// Reset bridge / level synchroniser: asynchronous clear, synchronous shift of i_d.
// Latency DEPTH cycles from i_d to o_q; i_arst_n low clears o_q immediately.
// No backpressure; free-running shift register.
module rst_sync_pf #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/reset_sequencer_mc.sv
// Multi-channel fabric reset sequencer; cause logging built only with RESET_CAUSE_LOG_EN defined.
// Latency: qualifier loss reaches the outputs SYNC_STAGES+1 cycles later; EXT_RST_N acts asynchronously.
// No backpressure; SW_RST_REQ is a level held by software until it wants the channels back.
module reset_sequencer_mc
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int STAGE_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              CLK,
  input  logic              EXT_RST_N,
  input  logic              PLL_LOCK,
  input  logic              INIT_DONE,
  input  logic              FF_US_RESTORE,
  input  logic [NUM_CH-1:0] SW_RST_REQ,
  input  logic              CAUSE_CLR,
  output logic [NUM_CH-1:0] FABRIC_RESET_N,
  output logic              SEQ_DONE,
  output logic [4:0]        RST_CAUSE
);

  localparam int               CNT_W    = $clog2(STAGE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STAGE_CYCLES);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_CH - 1);

  logic w_rst_rel_n;
  logic w_pll_s;
  logic w_init_s;
  logic w_ff_s;
  logic w_qual;

  rst_sync_pf #(.DEPTH(2)) u_rst_bridge (
    .i_clk(CLK), .i_arst_n(EXT_RST_N), .i_d(1'b1), .o_q(w_rst_rel_n)
  );
  rst_sync_pf #(.DEPTH(SYNC_STAGES)) u_sync_pll (
    .i_clk(CLK), .i_arst_n(EXT_RST_N), .i_d(PLL_LOCK), .o_q(w_pll_s)
  );
  rst_sync_pf #(.DEPTH(SYNC_STAGES)) u_sync_init (
    .i_clk(CLK), .i_arst_n(EXT_RST_N), .i_d(INIT_DONE), .o_q(w_init_s)
  );
  rst_sync_pf #(.DEPTH(SYNC_STAGES)) u_sync_ff (
    .i_clk(CLK), .i_arst_n(EXT_RST_N), .i_d(FF_US_RESTORE), .o_q(w_ff_s)
  );

  // The bridged external reset is folded into qual so the FSM cannot leave HOLD early.
  assign w_qual = w_pll_s & w_init_s & ~w_ff_s & w_rst_rel_n;

  seq_state_e        r_state;
  logic [NUM_CH-1:0] r_fab;
  logic              r_done;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_idx;

  logic              w_sw_any;
  logic [2:0]        w_sw_lo;
  logic [2:0]        w_idx_nxt;
  logic [2:0]        w_rel_j;
  logic [2:0]        w_abort_j;
  logic [NUM_CH-1:0] w_rel_msk;
  logic [NUM_CH-1:0] w_keep;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_cnt_done;
  logic              w_last;
  logic              w_do_abort;
  logic              w_do_rel;

  assign w_sw_any   = |SW_RST_REQ;
  assign w_sw_lo    = lowest_set(8'(SW_RST_REQ));
  assign w_idx_nxt  = r_idx + 3'd1;
  assign w_cnt_inc  = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  // A request above the next unreleased channel restarts from that channel, so none is skipped.
  always_comb begin
    w_rel_j   = 3'd0;
    w_abort_j = w_sw_lo;
    case (r_state)
      ST_RELEASE: begin
        w_rel_j   = w_idx_nxt;
        w_abort_j = (w_sw_lo < w_idx_nxt) ? w_sw_lo : w_idx_nxt;
      end
      ST_SW_HOLD, ST_SW_WAIT: begin
        w_rel_j   = r_idx;
        w_abort_j = (w_sw_lo < r_idx) ? w_sw_lo : r_idx;
      end
      default: ;
    endcase
  end

  assign w_rel_msk = NUM_CH'(1) << w_rel_j;
  assign w_keep    = (NUM_CH'(1) << w_abort_j) - NUM_CH'(1);
  assign w_last    = (w_rel_j == IDX_LAST);

  assign w_do_abort = w_sw_any && (r_state == ST_RELEASE || r_state == ST_RUN ||
                                   r_state == ST_SW_HOLD || r_state == ST_SW_WAIT);
  assign w_do_rel   = !w_do_abort && w_cnt_done &&
                      (r_state == ST_WAIT_STABLE || r_state == ST_RELEASE || r_state == ST_SW_WAIT);

  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      r_state <= ST_HOLD;
      r_fab   <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else if (!w_qual) begin
      r_state <= ST_HOLD;
      r_fab   <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else if (w_do_abort) begin
      r_state <= ST_SW_HOLD;
      r_idx   <= w_abort_j;
      r_fab   <= r_fab & w_keep;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_do_rel) begin
      r_fab <= r_fab | w_rel_msk;
      r_idx <= w_rel_j;
      r_cnt <= '0;
      if (w_last) begin
        r_state <= ST_RUN;
        r_done  <= 1'b1;
      end else begin
        r_state <= ST_RELEASE;
      end
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_state <= ST_WAIT_STABLE;
          r_cnt   <= '0;
        end
        ST_WAIT_STABLE, ST_RELEASE, ST_SW_WAIT: r_cnt <= w_cnt_inc;
        ST_SW_HOLD: begin
          r_state <= ST_SW_WAIT;
          r_cnt   <= '0;
        end
        ST_RUN: ;
        default: r_state <= ST_HOLD;
      endcase
    end
  end

  assign FABRIC_RESET_N = r_fab;
  assign SEQ_DONE       = r_done;

`ifdef RESET_CAUSE_LOG_EN
  logic         r_pll_d;
  logic         r_init_d;
  logic         r_ff_d;
  logic [4:0]   r_cause;
  logic [4:0]   w_cause_set;

  always_comb begin
    w_cause_set             = '0;
    w_cause_set[CAUSE_PLL]  = r_pll_d & ~w_pll_s;
    w_cause_set[CAUSE_INIT] = r_init_d & ~w_init_s;
    w_cause_set[CAUSE_FF]   = ~r_ff_d & w_ff_s;
    w_cause_set[CAUSE_SW]   = w_sw_any;
  end

  // A new event in the clearing cycle survives the clear.
  always_ff @(posedge CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      r_pll_d  <= 1'b0;
      r_init_d <= 1'b0;
      r_ff_d   <= 1'b0;
      r_cause  <= CAUSE_RST_VAL;
    end else begin
      r_pll_d  <= w_pll_s;
      r_init_d <= w_init_s;
      r_ff_d   <= w_ff_s;
      r_cause  <= (CAUSE_CLR ? 5'd0 : r_cause) | w_cause_set;
    end
  end

  assign RST_CAUSE = r_cause;
`else
  logic w_unused_cause_clr;
  assign w_unused_cause_clr = CAUSE_CLR;
  assign RST_CAUSE          = '0;
`endif

endmodule

// File: doc/reset_sequencer_mc.md
RESET_SEQUENCER_MC -- requirements
Module: reset_sequencer_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, range 1..8: number of sequenced fabric reset channels.
REQ-002 SHALL have parameter STAGE_CYCLES, default 16, range 2..65535: stability wait and inter-channel release spacing, in CLK cycles.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, range 2..4: synchroniser depth for the qualifier inputs.
REQ-004 SHALL have the following ports, one per line as name, direction, width, meaning:
- CLK  in  1  single clock; all logic in this domain.
- EXT_RST_N  in  1  reset, asynchronous assert, active-low.
- PLL_LOCK  in  1  asynchronous; PLL locked.
- INIT_DONE  in  1  asynchronous; device initialisation complete.
- FF_US_RESTORE  in  1  asynchronous; flash-freeze restore in progress.
- SW_RST_REQ  in  NUM_CH  synchronous level; software reset request per channel.
- CAUSE_CLR  in  1  synchronous single-cycle pulse; clears RST_CAUSE.
- FABRIC_RESET_N  out  NUM_CH  registered; per-channel reset, active-low.
- SEQ_DONE  out  1  registered; all channels released.
- RST_CAUSE  out  5  registered, sticky; bit0 EXT, bit1 PLL_LOCK loss, bit2 INIT_DONE loss, bit3 FF_US_RESTORE, bit4 SW.

Function
REQ-005 SHALL pass PLL_LOCK, INIT_DONE and FF_US_RESTORE through SYNC_STAGES flops, each reset to 0; qual = PLL_LOCK_s & INIT_DONE_s & ~FF_US_RESTORE_s.
REQ-006 SHALL implement the FSM HOLD -> WAIT_STABLE -> RELEASE -> RUN, with reset state HOLD.
REQ-007 HOLD: all FABRIC_RESET_N = 0 and SEQ_DONE = 0; move to WAIT_STABLE when qual = 1.
REQ-008 WAIT_STABLE: count STAGE_CYCLES consecutive cycles of qual = 1, then enter RELEASE with channel index 0.
REQ-009 RELEASE: drive FABRIC_RESET_N[k] = 1 on entry for index k.
REQ-010 RELEASE: release channel k+1 exactly STAGE_CYCLES cycles after channel k, in ascending order; after the last channel, enter RUN.
REQ-011 RUN: SEQ_DONE = 1; SEQ_DONE SHALL rise in the same cycle that FABRIC_RESET_N[NUM_CH-1] rises.
REQ-012 qual = 0 in any state SHALL, on the next clock edge, force all channels to 0, clear SEQ_DONE, reset the counter and enter HOLD; this takes priority over all other transitions.
REQ-013 SW_RST_REQ[i] = 1 in RUN or RELEASE SHALL, on the next edge, force channels i..NUM_CH-1 to 0 and clear SEQ_DONE, leaving channels below i untouched.
REQ-014 After REQ-013, the block SHALL wait until SW_RST_REQ is all 0, then wait STAGE_CYCLES, then re-enter RELEASE at the lowest requested index i.
REQ-015 With several SW_RST_REQ bits set, the lowest set index SHALL govern.
REQ-016 SW_RST_REQ in HOLD or WAIT_STABLE SHALL be ignored for sequencing but SHALL still set the SW cause bit.
REQ-017 The stage counter SHALL be ceil(log2(STAGE_CYCLES+1)) bits wide, saturate, and never wrap.

Reset
REQ-018 EXT_RST_N = 0 SHALL asynchronously drive FABRIC_RESET_N = 0, SEQ_DONE = 0, FSM = HOLD, counters = 0 and synchronisers = 0.
REQ-019 Deassertion of EXT_RST_N SHALL be synchronised internally through 2 flops before the FSM leaves HOLD.
REQ-020 EXT_RST_N asserted mid-sequence SHALL abort the sequence immediately with no partial channel left released.

Configuration
REQ-021 With RESET_CAUSE_LOG_EN defined:
- RST_CAUSE SHALL reset to 5'b00001.
- RST_CAUSE SHALL set a bit on each corresponding event (qualifier falling edge or SW request).
- RST_CAUSE SHALL clear on CAUSE_CLR.
- A set and a clear in the same cycle SHALL result in set.
REQ-022 Without RESET_CAUSE_LOG_EN, RST_CAUSE SHALL be constant 0, CAUSE_CLR SHALL be ignored, and no cause flops SHALL be inferred.

Structure
REQ-023 A shared package reset_seq_pkg SHALL hold the FSM state enum and the RST_CAUSE bit-position constants.
REQ-024 The reset bridge SHALL be sub-module rst_sync_pf, parametrised depth, asynchronous assert and synchronous release; it SHALL be reused for the qualifier synchronisers.

Verification
REQ-025 Defaults; all qualifiers good; EXT_RST_N rising -> channel 0 releases 16..24 cycles later; channels 1, 2, 3 follow at exactly +16, +32, +48 cycles; SEQ_DONE rises with channel 3.
REQ-026 In RUN, PLL_LOCK drops for 1 cycle -> all FABRIC_RESET_N = 0 within SYNC_STAGES+1 cycles; full re-sequence follows; RST_CAUSE = 5'b00011 (macro on).
REQ-027 In RUN, SW_RST_REQ = 4'b0100 for 5 cycles -> channels 2 and 3 go low, channels 0 and 1 stay high; channel 2 re-releases 16 cycles after the request clears, channel 3 16 cycles later.
REQ-028 FF_US_RESTORE = 1 during WAIT_STABLE at count 10 -> return to HOLD; counter restarts from 0 once qual returns; no channel releases early.
REQ-029 EXT_RST_N pulsed low during RELEASE after channel 1 is released -> all outputs go 0 asynchronously within the same cycle.
REQ-030 CAUSE_CLR coincident with INIT_DONE loss -> bit2 = 1 and all other bits = 0; with the macro off -> RST_CAUSE = 0 throughout.
